// File: rtl/ma_pkg.sv
// Shared constants, types and helpers for the moving-average inverse decoder.
package ma_pkg;

   // Ceiling log2, usable in parameter expressions.
   function automatic int ma_clog2(input int v);
      int r;
      int t;
      r = 0;
      t = v - 1;
      while (t > 0) begin
         r++;
         t = t >>> 1;
      end
      return r;
   endfunction

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int SW = DW + ma_clog2(N);

   typedef logic signed [DW-1:0] sample_t;
   typedef logic signed [SW-1:0] sum_t;
   typedef logic signed [SW+1:0] wide_t;

   typedef enum logic {ST_FILL, ST_RUN} state_t;

   // Clamp a wide difference to the sample range.
   function automatic sample_t sat_to_sample(input wide_t d);
      wide_t hi;
      wide_t lo;
      hi = wide_t'((2 ** (DW - 1)) - 1);
      lo = -hi - wide_t'(1);
      if (d > hi)      return sample_t'(hi);
      else if (d < lo) return sample_t'(lo);
      else             return d[DW-1:0];
   endfunction

endpackage

// File: rtl/ma_history_ring.sv
// N-entry ring of reconstructed samples; exposes the oldest entry x[n-N].
module ma_history_ring
   import ma_pkg::*;
#(
   parameter int N  = ma_pkg::N,
   parameter int DW = ma_pkg::DW
) (
   input  logic          system1000,
   input  logic          system1000_rstn,
   input  logic          i_we,
   input  logic [DW-1:0] i_wdata,
   output logic [DW-1:0] o_oldest
);

   localparam int PW = (ma_clog2(N) < 1) ? 1 : ma_clog2(N);

   logic [N-1:0][DW-1:0] r_mem;
   logic [PW-1:0]        r_wp;

   // The slot about to be overwritten holds the oldest sample (read-before-write).
   assign o_oldest = r_mem[r_wp];

   // Write the new sample over the oldest one and advance the pointer with wrap.
   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         r_mem <= '0;
         r_wp  <= '0;
      end else if (i_we) begin
         r_mem[r_wp] <= i_wdata;
         r_wp        <= (r_wp == PW'(N - 1)) ? '0 : r_wp + PW'(1);
      end
   end

endmodule

// File: rtl/moving_average_inverse.sv
// Reconstructs x[n] from an N-tap moving sum: x[n] = s[n] - s[n-1] + x[n-N].
module moving_average_inverse
   import ma_pkg::*;
#(
   parameter int N  = ma_pkg::N,
   parameter int DW = ma_pkg::DW,
   parameter int SW = DW + ma_clog2(N)
) (
   input  logic          system1000,
   input  logic          system1000_rstn,
   input  logic [SW-1:0] sum_i,
   input  logic          sum_valid_i,
   output logic [DW-1:0] x_o,
   output logic          x_valid_o,
   output logic          primed_o,
   output logic          ovf_o
);

   localparam int CW = ma_clog2(N + 1);

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [SW-1:0]   r_s_prev;
   logic [DW-1:0]   w_oldest;
   logic [SW+1:0]   w_d;
   logic            w_pos;
   logic            w_neg;
   logic [DW-1:0]   w_y;

   ma_history_ring #(.N(N), .DW(DW)) u_ring (
      .system1000      (system1000),
      .system1000_rstn (system1000_rstn),
      .i_we            (sum_valid_i),
      .i_wdata         (w_y),
      .o_oldest        (w_oldest)
   );

   // Full-width difference; SW+2 bits holds every reachable value exactly.
   assign w_d = {{2{sum_i[SW-1]}}, sum_i}
              - {{2{r_s_prev[SW-1]}}, r_s_prev}
              + {{(SW+2-DW){w_oldest[DW-1]}}, w_oldest};

   // Out of range when the bits above the sample's sign bit disagree with the sign.
   assign w_pos = ~w_d[SW+1] &  (|w_d[SW:DW-1]);
   assign w_neg =  w_d[SW+1] & ~(&w_d[SW:DW-1]);
   assign w_y   = w_pos ? {1'b0, {(DW-1){1'b1}}} :
                  w_neg ? {1'b1, {(DW-1){1'b0}}} : w_d[DW-1:0];

   // Output registers, sticky overflow and FILL/RUN priming state machine.
   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         r_state   <= ST_FILL;
         r_cnt     <= '0;
         r_s_prev  <= '0;
         x_o       <= '0;
         x_valid_o <= 1'b0;
         primed_o  <= 1'b0;
         ovf_o     <= 1'b0;
      end else begin
         x_valid_o <= sum_valid_i;
         if (sum_valid_i) begin
            x_o      <= w_y;
            r_s_prev <= sum_i;
            if (w_pos || w_neg) ovf_o <= 1'b1;
            case (r_state)
               ST_FILL: begin
                  r_cnt <= r_cnt + CW'(1);
                  if (r_cnt == CW'(N - 1)) begin
                     r_state  <= ST_RUN;
                     primed_o <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/moving_average_inverse.md
Name: moving_average_inverse

Overview:
- Decoder-side counterpart of the moving-average filter.
- Takes the full-precision N-tap moving sum s[n] produced by the averager datapath and reconstructs the original signed input sample stream x[n].
- Recursion: x[n] = s[n] - s[n-1] + x[n-N].
- Used in loopback/self-check paths: averager -> inverse -> compare against stimulus.

Parameters:
- N, 4, window length in taps, 2..64.
- DW, 8, sample width, signed.
- SW, DW+clog2(N), moving-sum input width, signed.

Ports:
- system1000  input  1  clock, rising edge.
- system1000_rstn  input  1  asynchronous reset, active low.
- sum_i  input  SW  signed moving sum s[n].
- sum_valid_i  input  1  sum_i valid this cycle.
- x_o  output  DW  signed reconstructed sample x[n].
- x_valid_o  output  1  x_o valid, one-cycle pulse per accepted sum.
- primed_o  output  1  high once N samples have been accepted since reset.
- ovf_o  output  1  sticky: a reconstructed value was saturated since reset.

Behaviour:
- Reset (async assert, sync-safe release): x_o=0, x_valid_o=0, primed_o=0, ovf_o=0.
- Reset state: s_prev=0, all N history entries=0, write pointer=0, accept counter=0.
- These initial conditions match the averager's all-zero reset state, so reconstruction is exact from the first sample.
- Accept condition: every cycle with sum_valid_i=1 accepts a sample. There is no backpressure.
- Latency: x_o and x_valid_o are registered, one cycle after acceptance.
- Idle cycles (sum_valid_i=0):
  - x_valid_o=0.
  - x_o holds its last value.
  - No state changes.
- Arithmetic:
  - d = sum_i - s_prev + hist[wp], computed in SW+2 bits signed with no intermediate truncation.
  - hist[wp] is the oldest entry, i.e. x[n-N].
  - If d > 2^(DW-1)-1 or d < -2^(DW-1): y = the saturated limit and ovf_o is set.
  - Otherwise y = d[DW-1:0].
- Update on accept, all in the same edge:
  - x_o <= y.
  - hist[wp] <= y. The saturated value is stored.
  - s_prev <= sum_i.
  - wp <= (wp == N-1) ? 0 : wp+1.
- Pointer wrap: after index N-1 the next write is index 0. A read and a write to the same entry in one cycle read the old value (read-before-write).
- Accept counter: saturates at N. primed_o=1 when the counter equals N, asserted with the x_valid_o of the Nth sample. primed_o is informational only and does not gate the output.
- ovf_o: sticky; cleared only by reset. It rises in the same cycle as the x_valid_o that carries the saturated value.
- Reset mid-stream: immediate return to reset state. The first sample after release is decoded against zero history.
- Single state machine with two states:
  - FILL: counter < N.
  - RUN: counter == N.
  - FILL -> RUN on the Nth accept.
  - RUN -> FILL only on reset.

Decomposition:
- Shared package ma_pkg:
  - Constants: N, DW, SW.
  - Typedefs: sample_t (signed DW), sum_t (signed SW), wide_t (signed SW+2).
  - Functions: sat_to_sample(wide_t) and the clog2 helper.
- Sub-module ma_history_ring:
  - N x DW register ring with write pointer and read-before-write oldest-entry output.
  - Reset to zero.
  - Same clock/reset ports.

Test Plan:
- N=4, x = 1,2,3,4,5,6, fed back-to-back as sums 1,3,6,10,14,18 -> x_o = 1,2,3,4,5,6, each one cycle after its sum. primed_o rises with the 4th output (x_o=4).
- Same sums with sum_valid_i low for 3 cycles between samples -> identical x_o sequence; x_valid_o only pulses one cycle after each valid sum; x_o stable during gaps.
- Extremes: x = 127,127,127,127,-128,-128,-128,-128, sums 127,254,381,508,253,-2,-257,-512 -> exact reconstruction, ovf_o stays 0.
- Corrupted sum: after reset, sum_i=200 -> x_o=127, ovf_o=1 and remains 1. Next sum 200 -> d = 0+0 = 0 (oldest entry still 0), so x_o=0.
- Reset mid-stream: assert system1000_rstn=0 after the 3rd sum of the first test -> all outputs 0 asynchronously. After release, sums 5,12 -> x_o = 5,7 and primed_o=0.
- Random regression: 10k random DW-bit samples through a reference N-tap summer into the DUT -> x_o equals the stimulus delayed one cycle, ovf_o=0 throughout. Repeat for N=2, 4 and 7 to exercise non-power-of-two wrap.
